// File: rtl/elem_writer.sv
// elem_writer
//   Writes fixed-size array elements (NDWORDS x 32-bit) to memory over a
//   16-bit Avalon-MM master. Each element becomes 2*NDWORDS halfword beats
//   starting at baseaddr + 4*NDWORDS*index. The lowest halfword is written to the lowest address.
//   One active element plus a one-entry queue.
//
// Ports
//   clk, reset_n          rising-edge clock, async active-low reset
//   baseaddr[31:0]        array byte base address (static)
//   index[31:0]           element index, captured on acceptance
//   data[ELEMSZ-1:0]      element contents, captured on acceptance
//   write / iready        request handshake (accepted when both high)
//   done                  one-cycle pulse after each element's last beat
//   busy                  element active or queued
//   avm_m0_*              Avalon-MM write master (16-bit data)
module elem_writer #(
    parameter  int NDWORDS = 9,
    localparam int ELEMSZ  = 32 * NDWORDS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       baseaddr,
    input  logic [31:0]       index,
    input  logic [ELEMSZ-1:0] data,
    input  logic              write,
    output logic              iready,
    output logic              done,
    output logic              busy,
    output logic              avm_m0_write,
    output logic [31:0]       avm_m0_address,
    output logic [15:0]       avm_m0_writedata,
    output logic [1:0]        avm_m0_byteenable,
    input  logic              avm_m0_waitrequest
);

    localparam int NBEATS = 2 * NDWORDS;
    localparam int BW     = $clog2(NBEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, NEXT} state_t;

    state_t             state_q,    state_d;
    logic [BW-1:0]      beat_q,     beat_d;
    logic [31:0]        act_addr_q, act_addr_d;
    logic [ELEMSZ-1:0]  act_data_q, act_data_d;
    logic               q_full_q,   q_full_d;
    logic [31:0]        q_addr_q,   q_addr_d;
    logic [ELEMSZ-1:0]  q_data_q,   q_data_d;
    logic               done_q,     done_d;

    logic               accept;
    logic               beat_fire;
    logic [31:0]        start_addr;

    assign iready     = !q_full_q;
    assign accept     = write && iready;
    assign beat_fire  = (state_q == WRITE) && !avm_m0_waitrequest;
    assign start_addr = baseaddr + 32'(4 * NDWORDS) * index;

    assign avm_m0_write      = (state_q == WRITE);
    assign avm_m0_address    = avm_m0_write ? act_addr_q + (32'(beat_q) << 1) : '0;
    assign avm_m0_writedata  = avm_m0_write ? act_data_q[16*beat_q +: 16] : '0;
    assign avm_m0_byteenable = avm_m0_write ? 2'b11 : 2'b00;
    assign done              = done_q;
    assign busy              = (state_q != IDLE) || q_full_q;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        act_addr_d = act_addr_q;
        act_data_d = act_data_q;
        q_full_d   = q_full_q;
        q_addr_d   = q_addr_q;
        q_data_d   = q_data_q;
        done_d     = 1'b0;

        // Any request accepted outside IDLE is queued; acceptance implies the
        // queue is empty, so this never collides with the dequeue paths below.
        if (accept && state_q != IDLE) begin
            q_addr_d = start_addr;
            q_data_d = data;
            q_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    act_addr_d = start_addr;
                    act_data_d = data;
                    beat_d     = '0;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                if (beat_fire) begin
                    if (beat_q == LAST_BEAT) begin
                        done_d = 1'b1;
                        beat_d = '0;
                        if (q_full_q) begin
                            act_addr_d = q_addr_q;
                            act_data_d = q_data_q;
                            q_full_d   = 1'b0;
                            state_d    = NEXT;
                        end else if (accept) begin
                            state_d = NEXT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            NEXT: begin
                // Queue still full here only when the request arrived on the
                // last-beat edge; it is promoted now. Otherwise the element
                // was already promoted and a new arrival stays queued.
                if (q_full_q) begin
                    act_addr_d = q_addr_q;
                    act_data_d = q_data_q;
                    q_full_d   = 1'b0;
                end
                beat_d  = '0;
                state_d = WRITE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            act_addr_q <= '0;
            act_data_q <= '0;
            q_full_q   <= 1'b0;
            q_addr_q   <= '0;
            q_data_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            act_addr_q <= act_addr_d;
            act_data_q <= act_data_d;
            q_full_q   <= q_full_d;
            q_addr_q   <= q_addr_d;
            q_data_q   <= q_data_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_elem_writer.sv
module tb_elem_writer;

    localparam int NDW    = 9;
    localparam int ELEMSZ = 32 * NDW;
    localparam int NB     = 2 * NDW;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [31:0]       baseaddr;
    logic [31:0]       index;
    logic [ELEMSZ-1:0] data;
    logic              write;
    logic              iready, done, busy;
    logic              avm_m0_write;
    logic [31:0]       avm_m0_address;
    logic [15:0]       avm_m0_writedata;
    logic [1:0]        avm_m0_byteenable;
    logic              avm_m0_waitrequest;

    always #5 clk = ~clk;

    elem_writer #(.NDWORDS(NDW)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .baseaddr           (baseaddr),
        .index              (index),
        .data               (data),
        .write              (write),
        .iready             (iready),
        .done               (done),
        .busy               (busy),
        .avm_m0_write       (avm_m0_write),
        .avm_m0_address     (avm_m0_address),
        .avm_m0_writedata   (avm_m0_writedata),
        .avm_m0_byteenable  (avm_m0_byteenable),
        .avm_m0_waitrequest (avm_m0_waitrequest)
    );

    typedef struct {
        logic [31:0] addr;
        logic [15:0] wd;
        bit          last;
    } beat_t;

    typedef struct {
        logic [31:0] base;
        logic [31:0] idx;
        logic [31:0] exp_start;
        int          lat;
    } vec_t;

    beat_t sb[$];
    beat_t mon_e;
    vec_t  tbl[5];
    int    checks   = 0;
    int    errors   = 0;
    int    done_cnt = 0;
    bit    last_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [ELEMSZ-1:0] rnd_elem();
        logic [ELEMSZ-1:0] r;
        for (int i = 0; i < NDW; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Scoreboard consumer: every completed beat pops one expected beat.
    always @(negedge clk) begin
        if (!reset_n) begin
            last_prev = 1'b0;
        end else begin
            if (done || last_prev) check("done_after_last", done, last_prev);
            if (done) begin
                done_cnt++;
                check("done_nowrite", avm_m0_write, 0);
            end
            last_prev = 1'b0;
            if (avm_m0_write) begin
                check("byteenable", avm_m0_byteenable, 2'b11);
                if (!avm_m0_waitrequest) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got addr %0h expected no beat", avm_m0_address);
                    end else begin
                        mon_e = sb.pop_front();
                        check("beat_addr", avm_m0_address, mon_e.addr);
                        check("beat_data", avm_m0_writedata, mon_e.wd);
                        last_prev = mon_e.last;
                    end
                end
            end
        end
    end

    // Called at posedge+#1 (or between edges); returns at accept-edge + #1.
    task automatic send(input logic [31:0] idx, input logic [ELEMSZ-1:0] d, output int waited);
        logic [31:0] st;
        waited = 0;
        write  = 1'b1;
        index  = idx;
        data   = d;
        @(negedge clk);
        while (!iready) begin
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
                write = 1'b0;
                return;
            end
            @(negedge clk);
        end
        st = baseaddr + idx * 32'd36;
        for (int b = 0; b < NB; b++)
            sb.push_back('{addr: st + 32'(2 * b), wd: d[16*b +: 16], last: (b == NB - 1)});
        @(posedge clk);
        #1;
        write = 1'b0;
        index = $urandom;
        data  = ~d;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy) begin
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout: got busy=1 expected busy=0 within 200 cycles");
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_rst();
        check("rst_write",  avm_m0_write, 0);
        check("rst_addr",   avm_m0_address, 0);
        check("rst_wdata",  avm_m0_writedata, 0);
        check("rst_be",     avm_m0_byteenable, 0);
        check("rst_done",   done, 0);
        check("rst_busy",   busy, 0);
        check("rst_iready", iready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1);
    end

    initial begin
        logic [ELEMSZ-1:0] d;
        int w, n, dc;

        tbl[0] = '{base: 32'h0000_1000, idx: 32'd2,          exp_start: 32'h0000_1048, lat: 19};
        tbl[1] = '{base: 32'hFFFF_FFF0, idx: 32'd1,          exp_start: 32'h0000_0014, lat: 19};
        tbl[2] = '{base: 32'h0000_0000, idx: 32'd0,          exp_start: 32'h0000_0000, lat: 19};
        tbl[3] = '{base: 32'h2000_0000, idx: 32'h10,         exp_start: 32'h2000_0240, lat: 19};
        tbl[4] = '{base: 32'h0000_0010, idx: 32'hFFFF_FFFF,  exp_start: 32'hFFFF_FFEC, lat: 19};

        reset_n = 1'b0;
        write = 1'b0;
        index = '0;
        data = '0;
        baseaddr = 32'h1000;
        avm_m0_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_rst();
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Single elements: start address, first data, latency to done.
        for (int i = 0; i < 5; i++) begin
            baseaddr = tbl[i].base;
            d = rnd_elem();
            dc = done_cnt;
            send(tbl[i].idx, d, w);
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == 1) begin
                    check("first_addr", avm_m0_address, tbl[i].exp_start);
                    check("first_data", avm_m0_writedata, d[15:0]);
                end
            end while (!done && n < 60);
            check("done_latency", n, tbl[i].lat);
            check("busy_after_done", busy, 0);
            @(posedge clk);
            #1;
            check("done_count_single", done_cnt - dc, 1);
        end

        // Stall beat 5 for three edges.
        baseaddr = 32'h1000;
        d = rnd_elem();
        dc = done_cnt;
        send(32'd2, d, w);
        repeat (5) @(posedge clk);
        #1 avm_m0_waitrequest = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_addr", avm_m0_address, 32'h1052);
            check("stall_data", avm_m0_writedata, d[95:80]);
            @(posedge clk);
        end
        #1 avm_m0_waitrequest = 1'b0;
        @(negedge clk);
        check("stall_addr_release", avm_m0_address, 32'h1052);
        wait_idle();
        check("done_count_stall", done_cnt - dc, 1);

        // Back-to-back: B queued, C held off until NEXT.
        dc = done_cnt;
        send(32'd0, rnd_elem(), w);
        send(32'd1, rnd_elem(), w);
        check("queue_accept_wait", w, 0);
        @(negedge clk);
        check("queue_full_iready", iready, 0);
        check("queue_full_busy", busy, 1);
        send(32'd2, rnd_elem(), w);
        check("third_held_cycles", w, 16);
        wait_idle();
        check("done_count_b2b", done_cnt - dc, 3);

        // Request accepted on the last-beat edge.
        dc = done_cnt;
        send(32'd4, rnd_elem(), w);
        repeat (17) @(posedge clk);
        #1;
        send(32'd5, rnd_elem(), w);
        check("lastedge_accept_wait", w, 0);
        @(negedge clk);
        check("lastedge_next_iready", iready, 0);
        check("lastedge_next_write", avm_m0_write, 0);
        check("lastedge_next_done", done, 1);
        wait_idle();
        check("done_count_lastedge", done_cnt - dc, 2);

        // Reset at beat 7 with an element queued.
        send(32'd6, rnd_elem(), w);
        send(32'd7, rnd_elem(), w);
        repeat (6) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_rst();
        sb.delete();
        dc = done_cnt;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check("post_reset_done_count", done_cnt - dc, 0);
        d = rnd_elem();
        send(32'd3, d, w);
        @(negedge clk);
        check("post_reset_first_addr", avm_m0_address, 32'h106C);
        check("post_reset_first_data", avm_m0_writedata, d[15:0]);
        wait_idle();
        check("done_count_post_reset", done_cnt - dc, 1);

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
